sram_arbiter: RTL and testbench

- Two-requester round-robin arbiter in front of the single-port async SRAM controller's command interface (addr / write / ena / busy / rd_data).
- Lets two independent agents share one SRAM, e.g. a list-writer and a pointer-chaser.
- Owns the ena/busy handshake: it raises ena until busy is seen, then drops it and waits for busy to clear.
- Returns read data and a completion pulse to the owning requester.

---
 rtl/sram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter for the async SRAM controller
// command interface (addr / write / ena / busy / rd_data).
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   pN_req/write/addr/wdata       request from port N (held until pN_ack)
//   pN_ack                        1-cycle pulse, request accepted
//   pN_done                       1-cycle pulse, operation complete
//   pN_rdata                      last read result for port N
//   pN_err                        1-cycle pulse with pN_done on timeout abort
//   mem_addr/write/wdata/ena      command to controller (held grant..IDLE)
//   mem_busy, mem_rdata           controller status / read data
//
// Build option: define SRAM_ARB_TIMEOUT_EN to bound each ISSUE/WAIT phase
// to TIMEOUT cycles. Without it the err outputs are constant 0.
module sram_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_write,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_write,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic          mem_ena,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_busy,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t               state, state_nxt;
  logic                 owner, last_grant;
  logic                 grant_vld, grant_port, abort, tmo;
  logic [1:0]           req;
  logic [1:0]           ack_q, done_q;
  logic [1:0][DW-1:0]   rdata_q;

  assign req = {p1_req, p0_req};

  always_comb begin
    state_nxt  = state;
    grant_vld  = 1'b0;
    grant_port = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: if (|req) begin
        grant_vld  = 1'b1;
        // on contention the port that did not win last time gets it
        grant_port = (req == 2'b11) ? ~last_grant : req[1];
        state_nxt  = ISSUE;
      end
      ISSUE: begin
        if (mem_busy) state_nxt = WAIT;
        else if (tmo) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (!mem_busy) state_nxt = DONE;
        else if (tmo) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      ack_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      mem_ena    <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state  <= state_nxt;
      ack_q  <= '0;
      done_q <= '0;
      if (grant_vld) begin
        owner             <= grant_port;
        last_grant        <= grant_port;
        ack_q[grant_port] <= 1'b1;
        mem_ena           <= 1'b1;
        mem_write         <= grant_port ? p1_write : p0_write;
        mem_addr          <= grant_port ? p1_addr  : p0_addr;
        mem_wdata         <= grant_port ? p1_wdata : p0_wdata;
      end
      // controller has taken the command; release ena
      if (state == ISSUE && mem_busy) mem_ena <= 1'b0;
      if (abort) begin
        mem_ena       <= 1'b0;
        done_q[owner] <= 1'b1;
      end
      if (state == DONE) begin
        done_q[owner] <= 1'b1;
        if (!mem_write) rdata_q[owner] <= mem_rdata;
      end
    end
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic [1:0]    err_q;

  // phase counter restarts on entry to ISSUE (grant) and to WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      err_q <= '0;
    end else begin
      err_q <= '0;
      if (abort) err_q[owner] <= 1'b1;
      if (grant_vld || (state == ISSUE && mem_busy)) cnt <= '0;
      else if (state == ISSUE || state == WAIT)      cnt <= cnt + 1'b1;
    end
  end

  // true in the TIMEOUT-th cycle of a phase
  assign tmo    = (state == ISSUE || state == WAIT) && (cnt == CW'(TIMEOUT - 1));
  assign p0_err = err_q[0];
  assign p1_err = err_q[1];
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo    = 1'b0;
  assign p0_err = 1'b0;
  assign p1_err = 1'b0;
`endif

  assign p0_ack   = ack_q[0];
  assign p1_ack   = ack_q[1];
  assign p0_done  = done_q[0];
  assign p1_done  = done_q[1];
  assign p0_rdata = rdata_q[0];
  assign p1_rdata = rdata_q[1];

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vector table plus hand-written sequences
// (reset mid-op, contention, write/read-chase, phase timeout).
module tb_sram_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p0_req = 1'b0, p0_write = 1'b0;
  logic [7:0] p0_addr = '0, p0_wdata = '0;
  logic       p1_req = 1'b0, p1_write = 1'b0;
  logic [7:0] p1_addr = '0, p1_wdata = '0;
  logic       p0_ack, p0_done, p0_err, p1_ack, p1_done, p1_err;
  logic [7:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
  logic       mem_write, mem_ena;
  logic       mem_busy = 1'b0;
  logic [7:0] mem_rdata = '0;

  always #5 clk = ~clk;

  sram_arbiter #(.AW(8), .DW(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_ena(mem_ena),
    .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_rdata(mem_rdata)
  );

  // controller model: takes ena while idle, stays busy for blen cycles
  logic [7:0] mem [256];
  int         blen = 2;
  int         mcnt = 0;
  logic       model_off = 1'b0;

  always @(posedge clk) begin
    if (!mem_busy) begin
      if (mem_ena && !model_off) begin
        mem_busy <= 1'b1;
        mcnt     <= blen - 1;
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else           mem_rdata     <= mem[mem_addr];
      end
    end else if (mcnt == 0) mem_busy <= 1'b0;
    else                    mcnt     <= mcnt - 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input int p);  return p ? p1_ack  : p0_ack;  endfunction
  function automatic logic done_of(input int p); return p ? p1_done : p0_done; endfunction
  function automatic logic err_of(input int p);  return p ? p1_err  : p0_err;  endfunction
  function automatic logic [7:0] rd_of(input int p); return p ? p1_rdata : p0_rdata; endfunction

  task automatic set_req(input int p, input logic r, input logic wr,
                         input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin p0_req = r; p0_write = wr; p0_addr = a; p0_wdata = d; end
    else        begin p1_req = r; p1_write = wr; p1_addr = a; p1_wdata = d; end
  endtask

  // one full transaction; checks ack latency, done latency (busy + 3),
  // command stability, other-port silence, rdata and err
  task automatic do_op(input int p, input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input int n, input logic [7:0] exp_rd,
                       input string name);
    int k;
    bit stable, quiet;
    blen = n;
    @(negedge clk);
    set_req(p, 1'b1, wr, a, d);
    k = 0;
    do begin @(negedge clk); k++; end while (!ack_of(p) && k < 10);
    chk({name, " ack_lat"}, k, 1);
    chk({name, " ena_issue"}, int'(mem_ena), 1);
    set_req(p, 1'b0, wr, a, d);
    k = 0; stable = 1; quiet = 1;
    do begin
      @(negedge clk); k++;
      if (mem_addr !== a || mem_write !== wr || (wr && mem_wdata !== d)) stable = 0;
      if (ack_of(1 - p) || done_of(1 - p) || err_of(1 - p) || ack_of(p)) quiet = 0;
    end while (!done_of(p) && k < 200);
    chk({name, " done_lat"}, k, n + 3);
    chk({name, " cmd_stable"}, int'(stable), 1);
    chk({name, " quiet"}, int'(quiet), 1);
    chk({name, " rdata"}, int'(rd_of(p)), int'(exp_rd));
    chk({name, " err"}, int'(err_of(p)), 0);
  endtask

  typedef struct {
    int         port;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         blen;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vt [8];

  task automatic chk_all_zero(input string name);
    chk(name, int'({p0_ack, p0_done, p0_err, p1_ack, p1_done, p1_err, mem_ena, mem_write}), 0);
    chk({name, " addr/wdata"}, int'({mem_addr, mem_wdata}), 0);
    chk({name, " rdata"}, int'({p0_rdata, p1_rdata}), 0);
  endtask

  initial begin
    int k, c0, c1, nd;
    int g [$];
    bit both;
    logic [7:0] ra;

    vt[0] = '{0, 1'b1, 8'h10, 8'h11, 2, 8'h00};
    vt[1] = '{0, 1'b0, 8'h10, 8'h00, 6, 8'h11};
    vt[2] = '{1, 1'b1, 8'h20, 8'h5A, 3, 8'h00};
    vt[3] = '{1, 1'b0, 8'h20, 8'h00, 1, 8'h5A};
    vt[4] = '{0, 1'b1, 8'hFF, 8'hC3, 2, 8'h11};
    vt[5] = '{0, 1'b0, 8'hFF, 8'h00, 4, 8'hC3};
    vt[6] = '{1, 1'b1, 8'h00, 8'hFF, 5, 8'h5A};
    vt[7] = '{1, 1'b0, 8'h00, 8'h00, 1, 8'hFF};

    // reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    for (int i = 0; i < 8; i++)
      do_op(vt[i].port, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].blen,
            vt[i].exp_rd, $sformatf("vec%0d", i));

    // reset while p0 read is in WAIT: everything clears at once, no done
    blen = 6;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("rst_mid ack", int'(p0_ack), 1);
    set_req(0, 1'b0, 1'b0, 8'h10, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin @(negedge clk); if (p0_done || p1_done) nd++; end
    chk("rst_mid no_done", nd, 0);
    do_op(0, 1'b0, 8'hFF, 8'h00, 2, 8'hC3, "after_rst");

    // contention from a fresh reset: port 0 first, then strict alternation
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    blen = 2; c0 = 0; c1 = 0; both = 0; k = 0;
    set_req(0, 1'b1, 1'b1, 8'h30, 8'hA0);
    set_req(1, 1'b1, 1'b1, 8'h31, 8'hB0);
    while (g.size() < 8 && k < 1000) begin
      @(negedge clk); k++;
      if (p0_ack && p1_ack) both = 1;
      if (p0_ack) begin g.push_back(0); c0++; p0_req = 1'b0; end
      else if (!p0_req && c0 < 4) p0_req = 1'b1;
      if (p1_ack) begin g.push_back(1); c1++; p1_req = 1'b0; end
      else if (!p1_req && c1 < 4) p1_req = 1'b1;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("cont grants", g.size(), 8);
    for (int i = 0; i < g.size(); i++) chk($sformatf("cont grant%0d", i), g[i], i % 2);
    chk("cont dual_ack", int'(both), 0);
    repeat (20) @(negedge clk);

    // back-to-back: a[i] = i+1, then chase pointers from 0
    for (int i = 0; i < 256; i++)
      do_op(0, 1'b1, 8'(i), 8'(i + 1), 1, 8'h00, $sformatf("w%0d", i));
    ra = 8'h00;
    for (int i = 0; i < 256; i++) begin
      do_op(0, 1'b0, ra, 8'h00, 1, 8'(i + 1), $sformatf("chase%0d", i));
      ra = 8'(i + 1);
    end

    // controller never answers
    model_off = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("tmo ack", int'(p0_ack), 1);
    set_req(0, 1'b0, 1'b0, 8'h10, 8'h00);
`ifdef SRAM_ARB_TIMEOUT_EN
    k = 0;
    do begin @(negedge clk); k++; end while (!p0_done && k < 50);
    chk("tmo lat", k, 8);
    chk("tmo err", int'(p0_err), 1);
    chk("tmo ena", int'(mem_ena), 0);
    chk("tmo rdata", int'(p0_rdata), 0);
`else
    nd = 0;
    repeat (20) begin @(negedge clk); if (p0_done || p0_err) nd++; end
    chk("hang no_done", nd, 0);
    chk("hang ena", int'(mem_ena), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    model_off = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
